// File: rtl/jk_ff_checker.sv
// Response checker for a bank of N JK flip-flops: mirrors them with a reference model and flags per-bit mismatches.
// Optional coverage counters and cov_done are built in when JK_COVERAGE_EN is defined.
module jk_ff_checker #(
    parameter int N           = 1,
    parameter int CNT_W       = 8,
    parameter int MIN_CHECKS  = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [N-1:0]     j,
    input  logic [N-1:0]     k,
    input  logic [N-1:0]     q,
    output logic [N-1:0]     model_q,
    output logic             mismatch,
    output logic [N-1:0]     mismatch_mask,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [1:0]       state,
    output logic             pass,
    output logic             fail
`ifdef JK_COVERAGE_EN
    ,
    output logic [CNT_W-1:0] cov_hold,
    output logic [CNT_W-1:0] cov_reset,
    output logic [CNT_W-1:0] cov_set,
    output logic [CNT_W-1:0] cov_toggle,
    output logic             cov_done
`endif
);

    localparam logic [1:0]       S_RESET = 2'b00;
    localparam logic [1:0]       S_CHECK = 2'b01;
    localparam logic [1:0]       S_FAIL  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      MIN_C   = MIN_CHECKS;

    logic [N-1:0] diff;
    logic [N-1:0] model_next;
    logic         active;
    logic         bad;

    assign diff   = q ^ model_q;
    assign bad    = |diff;
    // The first edge out of RESET already compares, so only FAIL suspends checking.
    assign active = (state != S_FAIL);

    always_comb begin
        model_next = model_q;
        for (int i = 0; i < N; i++) begin
            case ({j[i], k[i]})
                2'b00:   model_next[i] = model_q[i];
                2'b01:   model_next[i] = 1'b0;
                2'b10:   model_next[i] = 1'b1;
                default: model_next[i] = ~model_q[i];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            model_q       <= '0;
            mismatch      <= 1'b0;
            mismatch_mask <= '0;
            err_count     <= '0;
            check_count   <= '0;
            state         <= S_RESET;
        end else begin
            model_q  <= model_next;
            mismatch <= 1'b0;
            if (active) begin
                if (check_count != CNT_MAX) check_count <= check_count + 1'b1;
                if (bad) begin
                    mismatch      <= 1'b1;
                    mismatch_mask <= diff;
                    if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
                end
                state <= (bad && STOP_ON_ERR != 0) ? S_FAIL : S_CHECK;
            end
        end
    end

    assign fail = (err_count != '0);

`ifdef JK_COVERAGE_EN
    logic [3:0] hit;
    assign hit[0] = |(~j & ~k);
    assign hit[1] = |(~j &  k);
    assign hit[2] = |( j & ~k);
    assign hit[3] = |( j &  k);

    always_ff @(posedge clock) begin
        if (rst) begin
            cov_hold   <= '0;
            cov_reset  <= '0;
            cov_set    <= '0;
            cov_toggle <= '0;
        end else if (active) begin
            if (hit[0] && cov_hold   != CNT_MAX) cov_hold   <= cov_hold   + 1'b1;
            if (hit[1] && cov_reset  != CNT_MAX) cov_reset  <= cov_reset  + 1'b1;
            if (hit[2] && cov_set    != CNT_MAX) cov_set    <= cov_set    + 1'b1;
            if (hit[3] && cov_toggle != CNT_MAX) cov_toggle <= cov_toggle + 1'b1;
        end
    end

    assign cov_done = (cov_hold != '0) && (cov_reset != '0) && (cov_set != '0) && (cov_toggle != '0);
    assign pass = (32'(check_count) >= MIN_C) && !fail && (state == S_CHECK) && cov_done;
`else
    assign pass = (32'(check_count) >= MIN_C) && !fail && (state == S_CHECK);
`endif

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: a sticky-fail 8-bit instance and a keep-going 4-bit instance share one stimulus stream.
module tb_jk_ff_checker;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic [0:0] j = '0, k = '0, q = '0;

    logic [0:0] a_mq, a_mask, b_mq, b_mask;
    logic       a_mm, a_pass, a_fail, b_mm, b_pass, b_fail;
    logic [7:0] a_err, a_cnt;
    logic [3:0] b_err, b_cnt;
    logic [1:0] a_st, b_st;
`ifdef JK_COVERAGE_EN
    logic [7:0] a_ch, a_cr, a_cs, a_ct;
    logic [3:0] b_ch, b_cr, b_cs, b_ct;
    logic       a_cd, b_cd;
`endif

    always #5 clock = ~clock;

    jk_ff_checker #(.N(1), .CNT_W(8), .MIN_CHECKS(16), .STOP_ON_ERR(1)) dut_a (
        .clock(clock), .rst(rst), .j(j), .k(k), .q(q),
        .model_q(a_mq), .mismatch(a_mm), .mismatch_mask(a_mask),
        .err_count(a_err), .check_count(a_cnt), .state(a_st),
        .pass(a_pass), .fail(a_fail)
`ifdef JK_COVERAGE_EN
        , .cov_hold(a_ch), .cov_reset(a_cr), .cov_set(a_cs), .cov_toggle(a_ct), .cov_done(a_cd)
`endif
    );

    jk_ff_checker #(.N(1), .CNT_W(4), .MIN_CHECKS(16), .STOP_ON_ERR(0)) dut_b (
        .clock(clock), .rst(rst), .j(j), .k(k), .q(q),
        .model_q(b_mq), .mismatch(b_mm), .mismatch_mask(b_mask),
        .err_count(b_err), .check_count(b_cnt), .state(b_st),
        .pass(b_pass), .fail(b_fail)
`ifdef JK_COVERAGE_EN
        , .cov_hold(b_ch), .cov_reset(b_cr), .cov_set(b_cs), .cov_toggle(b_ct), .cov_done(b_cd)
`endif
    );

    typedef struct {
        int mq;
        int mm[2];
        int mask[2];
        int err[2];
        int cnt[2];
        int st[2];
        int pass[2];
        int fail[2];
        int cdone;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    // Bench reference: JK state (also acts as the fault-free DUT) and checker state for both instances.
    int jk_q = 0;
    int m_st[2], m_cnt[2], m_err[2], m_mm[2], m_mask[2];
    int cv[4];
    int maxv[2] = '{255, 15};
    int stop[2] = '{1, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int jj, input int kk, input int rr, input int ff);
        exp_t e;
        int diff;
        int cdone;
        j   = 1'(jj);
        k   = 1'(kk);
        rst = 1'(rr);
        q   = 1'(jk_q ^ ff);
        diff = ff;
        if (rr != 0) begin
            for (int c = 0; c < 4; c++) cv[c] = 0;
        end else if (m_st[0] != 2) begin
            if (cv[jj*2+kk] < 255) cv[jj*2+kk]++;
        end
        for (int i = 0; i < 2; i++) begin
            if (rr != 0) begin
                m_st[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_mm[i] = 0; m_mask[i] = 0;
            end else begin
                m_mm[i] = 0;
                if (m_st[i] != 2) begin
                    if (m_cnt[i] < maxv[i]) m_cnt[i]++;
                    if (diff != 0) begin
                        m_mm[i] = 1;
                        m_mask[i] = diff;
                        if (m_err[i] < maxv[i]) m_err[i]++;
                    end
                    m_st[i] = (diff != 0 && stop[i] != 0) ? 2 : 1;
                end
            end
        end
        if (rr != 0) jk_q = 0;
        else if (jj == 1 && kk == 1) jk_q = 1 - jk_q;
        else if (jj == 1) jk_q = 1;
        else if (kk == 1) jk_q = 0;
        cdone = (cv[0] != 0 && cv[1] != 0 && cv[2] != 0 && cv[3] != 0) ? 1 : 0;
        e.mq = jk_q;
        e.cdone = cdone;
        for (int i = 0; i < 2; i++) begin
            e.mm[i] = m_mm[i]; e.mask[i] = m_mask[i]; e.err[i] = m_err[i];
            e.cnt[i] = m_cnt[i]; e.st[i] = m_st[i];
            e.fail[i] = (m_err[i] != 0) ? 1 : 0;
            e.pass[i] = (m_cnt[i] >= 16 && m_err[i] == 0 && m_st[i] == 1) ? 1 : 0;
`ifdef JK_COVERAGE_EN
            if (cdone == 0) e.pass[i] = 0;
`endif
        end
        sb.push_back(e);

        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("a_model_q", 32'(a_mq), 32'(e.mq));
        chk("a_mismatch", 32'(a_mm), 32'(e.mm[0]));
        chk("a_mask", 32'(a_mask), 32'(e.mask[0]));
        chk("a_err_count", 32'(a_err), 32'(e.err[0]));
        chk("a_check_count", 32'(a_cnt), 32'(e.cnt[0]));
        chk("a_state", 32'(a_st), 32'(e.st[0]));
        chk("a_pass", 32'(a_pass), 32'(e.pass[0]));
        chk("a_fail", 32'(a_fail), 32'(e.fail[0]));
        chk("b_model_q", 32'(b_mq), 32'(e.mq));
        chk("b_mismatch", 32'(b_mm), 32'(e.mm[1]));
        chk("b_err_count", 32'(b_err), 32'(e.err[1]));
        chk("b_check_count", 32'(b_cnt), 32'(e.cnt[1]));
        chk("b_state", 32'(b_st), 32'(e.st[1]));
        chk("b_fail", 32'(b_fail), 32'(e.fail[1]));
`ifdef JK_COVERAGE_EN
        chk("a_cov_done", 32'(a_cd), 32'(e.cdone));
`endif
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_mm[i] = 0; m_mask[i] = 0;
        end
        for (int c = 0; c < 4; c++) cv[c] = 0;

        // Reset for two cycles, then the basic JK walk.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);

        // Toggle for 20 cycles; pass rises once 16 compares are in.
        step(0, 0, 1, 0);
        for (int n = 0; n < 20; n++) step(1, 1, 0, 0);

        // Single-cycle fault while model_q is 0, then observe FAIL stickiness.
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);

        // One-cycle reset from FAIL, then resume.
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Constant mismatch: the 4-bit instance saturates both counters.
        for (int n = 0; n < 20; n++) step(0, 0, 0, 1);

        // Coverage walk: every JK code once, then holds.
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        for (int n = 0; n < 12; n++) step(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
